// File: rtl/booth_mul_arbiter_if.sv
// rtl/booth_mul_arbiter_if.sv - request, multiplier and response bundle for booth_mul_arbiter
//
// Purpose: groups the requester handshake, the multiplier start/done link and the
// response handshake of the shared Booth multiplier arbiter into one interface.
// Ports (signal directions seen from the arbiter, modport slave):
//   i_req_valid   [N_REQ]        per-requester request valid
//   i_req_a       [N_REQ*WIDTH]  multiplicands, requester k at [k*WIDTH +: WIDTH]
//   i_req_b       [N_REQ*WIDTH]  multipliers, same packing
//   o_req_ready   [N_REQ]        one-hot accept
//   o_mul_start                  one-cycle start pulse to the multiplier
//   o_mul_m       [WIDTH]        latched multiplicand
//   o_mul_q       [WIDTH]        latched multiplier
//   i_mul_done                   multiplier result valid
//   i_mul_product [2*WIDTH]      multiplier result
//   o_rsp_valid                  response valid
//   o_rsp_id      [ID_W]         requester index of the response
//   o_rsp_product [2*WIDTH]      captured product
//   o_rsp_err                    timeout flag
//   i_rsp_ready                  consumer accepts response
// The master modport is the environment side (requesters, multiplier, consumer).

interface booth_mul_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]       i_req_valid;
  logic [N_REQ*WIDTH-1:0] i_req_a;
  logic [N_REQ*WIDTH-1:0] i_req_b;
  logic [N_REQ-1:0]       o_req_ready;
  logic                   o_mul_start;
  logic [WIDTH-1:0]       o_mul_m;
  logic [WIDTH-1:0]       o_mul_q;
  logic                   i_mul_done;
  logic [2*WIDTH-1:0]     i_mul_product;
  logic                   o_rsp_valid;
  logic [ID_W-1:0]        o_rsp_id;
  logic [2*WIDTH-1:0]     o_rsp_product;
  logic                   o_rsp_err;
  logic                   i_rsp_ready;

  modport slave (
    input  i_req_valid, i_req_a, i_req_b, i_mul_done, i_mul_product, i_rsp_ready,
    output o_req_ready, o_mul_start, o_mul_m, o_mul_q,
    output o_rsp_valid, o_rsp_id, o_rsp_product, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_a, i_req_b, i_mul_done, i_mul_product, i_rsp_ready,
    input  o_req_ready, o_mul_start, o_mul_m, o_mul_q,
    input  o_rsp_valid, o_rsp_id, o_rsp_product, o_rsp_err
  );
endinterface

// File: rtl/booth_mul_arbiter.sv
// rtl/booth_mul_arbiter.sv - round-robin arbiter sharing one Booth multiplier
//
// Purpose: grants one of N_REQ requesters at a time (round robin), latches its
// operands, pulses the multiplier start, waits for done with a TIMEOUT-cycle limit
// and returns the product (or a timeout error) tagged with the requester index.
// Ports:
//   i_clk    clock, rising edge
//   i_rst_n  synchronous active-low reset
//   bus      booth_mul_arbiter_if.slave: requester, multiplier and response signals

module booth_mul_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  booth_mul_arbiter_if.slave   bus
);

  localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_RESP} state_t;

  state_t             state_q, state_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [WIDTH-1:0]   op_a_q, op_a_d;
  logic [WIDTH-1:0]   op_b_q, op_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic               err_q, err_d;

  logic               found;
  logic [ID_W-1:0]    winner;
  logic [ID_W-1:0]    cand;
  logic [N_REQ-1:0]   grant;

  // Index base+off modulo N_REQ; off never exceeds N_REQ so one subtraction suffices.
  function automatic logic [ID_W-1:0] wrap_add(logic [ID_W-1:0] base, int off);
    int s;
    s = int'(base) + off;
    if (s >= N_REQ) s = s - N_REQ;
    return ID_W'(s);
  endfunction

  // Search starts just after the last winner so the last winner has lowest priority.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = wrap_add(ptr_q, i);
      if (!found && bus.i_req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Grant is only offered in IDLE and never while reset is held, so no requester
  // sees a transfer that the reset edge would throw away.
  always_comb begin
    grant = '0;
    if (found && (state_q == S_IDLE) && i_rst_n) grant[winner] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (|grant) begin
          op_a_d  = bus.i_req_a[int'(winner)*WIDTH +: WIDTH];
          op_b_d  = bus.i_req_b[int'(winner)*WIDTH +: WIDTH];
          id_d    = winner;
          ptr_d   = winner;
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_BUSY;
      end
      S_BUSY: begin
        // done takes precedence over expiry in the same cycle
        if (bus.i_mul_done) begin
          prod_d  = bus.i_mul_product;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          prod_d  = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= ID_W'(N_REQ - 1);
      id_q    <= '0;
      op_a_q  <= '0;
      op_b_q  <= '0;
      cnt_q   <= '0;
      prod_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      err_q   <= err_d;
    end
  end

  assign bus.o_req_ready   = grant;
  assign bus.o_mul_start   = (state_q == S_START);
  assign bus.o_mul_m       = op_a_q;
  assign bus.o_mul_q       = op_b_q;
  assign bus.o_rsp_valid   = (state_q == S_RESP);
  assign bus.o_rsp_id      = id_q;
  assign bus.o_rsp_product = prod_q;
  assign bus.o_rsp_err     = err_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// tb/tb_booth_mul_arbiter.sv - self-checking bench for booth_mul_arbiter

module tb_booth_mul_arbiter;
  localparam int N  = 4;
  localparam int W  = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  booth_mul_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  booth_mul_arbiter #(.N_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // transaction-level model: 0 idle, 1 start, 2 busy, 3 response
  int           m_stage = 0;
  int           m_ptr = N - 1;
  int           m_k = 0;
  int           done_at = 0;
  int           xfer_count = 0;
  int           start_pulses = 0;
  int           last_busy = 0;
  int           resp_cycles = 0;
  int           last_resp_cycles = 0;
  int           exp_id = 0;
  logic [W-1:0]   exp_a = '0, exp_b = '0;
  logic [2*W-1:0] exp_prod = '0;
  logic           exp_err = 1'b0;
  bit             just_reset = 1'b0;
  int             grants[$];

  // stimulus configuration
  bit           cfg_rand = 1'b0;
  logic [N-1:0] cfg_valid = '0;
  logic [W-1:0] cfg_a [N];
  logic [W-1:0] cfg_b [N];
  int           cfg_limit = 0;
  int           cfg_done_at = -1;
  int           cfg_rsp_mode = 0;
  int           hold_cnt = 0;
  bit           force_done = 1'b0;

  function automatic logic [2*W-1:0] smul(logic [W-1:0] a, logic [W-1:0] b);
    int pa, pb;
    pa = int'($signed(a));
    pb = int'($signed(b));
    return (2*W)'(pa * pb);
  endfunction

  function automatic int rr_winner(int ptr, logic [N-1:0] v);
    for (int i = 1; i <= N; i++)
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    return -1;
  endfunction

  always @(negedge clk) begin
    int w;
    logic [N-1:0] exp_ready;
    logic [N-1:0] one;
    one = 1;
    if (!rst_n) begin
      m_stage    <= 0;
      m_ptr      <= N - 1;
      exp_a      <= '0;
      exp_b      <= '0;
      resp_cycles <= 0;
      just_reset <= 1'b1;
    end else begin
      if (just_reset) begin
        chk("reset_rsp_id", bus.o_rsp_id, 0);
        chk("reset_rsp_product", bus.o_rsp_product, 0);
        chk("reset_rsp_err", bus.o_rsp_err, 0);
        just_reset <= 1'b0;
      end
      chk("mul_m", bus.o_mul_m, exp_a);
      chk("mul_q", bus.o_mul_q, exp_b);
      case (m_stage)
        0: begin
          w = rr_winner(m_ptr, bus.i_req_valid);
          exp_ready = (w >= 0) ? (one << w) : '0;
          chk("req_ready_idle", bus.o_req_ready, exp_ready);
          chk("start_idle", bus.o_mul_start, 0);
          chk("rsp_valid_idle", bus.o_rsp_valid, 0);
          if (w >= 0) begin
            m_stage    <= 1;
            m_ptr      <= w;
            exp_id     <= w;
            exp_a      <= bus.i_req_a[w*W +: W];
            exp_b      <= bus.i_req_b[w*W +: W];
            xfer_count <= xfer_count + 1;
            grants.push_back(w);
            done_at    <= (cfg_done_at >= 0) ? cfg_done_at : int'($urandom_range(0, 20));
          end
        end
        1: begin
          chk("req_ready_start", bus.o_req_ready, 0);
          chk("start_pulse", bus.o_mul_start, 1);
          chk("rsp_valid_start", bus.o_rsp_valid, 0);
          start_pulses <= start_pulses + 1;
          m_stage <= 2;
          m_k     <= 1;
        end
        2: begin
          chk("req_ready_busy", bus.o_req_ready, 0);
          chk("start_busy", bus.o_mul_start, 0);
          chk("rsp_valid_busy", bus.o_rsp_valid, 0);
          if (bus.i_mul_done) begin
            exp_prod  <= smul(exp_a, exp_b);
            exp_err   <= 1'b0;
            last_busy <= m_k;
            m_stage   <= 3;
          end else if (m_k == TO) begin
            exp_prod  <= '0;
            exp_err   <= 1'b1;
            last_busy <= m_k;
            m_stage   <= 3;
          end else begin
            m_k <= m_k + 1;
          end
        end
        default: begin
          chk("req_ready_resp", bus.o_req_ready, 0);
          chk("start_resp", bus.o_mul_start, 0);
          chk("rsp_valid", bus.o_rsp_valid, 1);
          chk("rsp_id", bus.o_rsp_id, exp_id);
          chk("rsp_product", bus.o_rsp_product, exp_prod);
          chk("rsp_err", bus.o_rsp_err, exp_err);
          resp_cycles <= resp_cycles + 1;
          if (bus.i_rsp_ready) begin
            last_resp_cycles <= resp_cycles + 1;
            resp_cycles      <= 0;
            m_stage          <= 0;
          end
        end
      endcase
    end
  end

  task automatic step();
    logic [N-1:0] v;
    @(posedge clk);
    #1;
    if (cfg_rand) begin
      v = N'($urandom);
      for (int k = 0; k < N; k++) begin
        bus.i_req_a[k*W +: W] = W'($urandom);
        bus.i_req_b[k*W +: W] = W'($urandom);
      end
    end else begin
      v = (xfer_count < cfg_limit) ? cfg_valid : '0;
      for (int k = 0; k < N; k++) begin
        bus.i_req_a[k*W +: W] = cfg_a[k];
        bus.i_req_b[k*W +: W] = cfg_b[k];
      end
    end
    bus.i_req_valid = v;
    if (m_stage == 2 && m_k == done_at) begin
      bus.i_mul_done    = 1'b1;
      bus.i_mul_product = smul(exp_a, exp_b);
    end else if (m_stage != 2 && (force_done || (cfg_rand && $urandom_range(0, 7) == 0))) begin
      bus.i_mul_done    = 1'b1;
      bus.i_mul_product = (2*W)'($urandom);
    end else begin
      bus.i_mul_done    = 1'b0;
      bus.i_mul_product = (2*W)'($urandom);
    end
    case (cfg_rsp_mode)
      0: bus.i_rsp_ready = 1'b1;
      1: bus.i_rsp_ready = 1'($urandom_range(0, 1));
      default: begin
        if (m_stage == 3 && hold_cnt < 5) begin
          bus.i_rsp_ready = 1'b0;
          hold_cnt++;
        end else begin
          bus.i_rsp_ready = 1'b1;
        end
      end
    endcase
  endtask

  task automatic do_reset();
    cfg_rand  = 1'b0;
    cfg_limit = xfer_count;
    bus.i_req_valid = '0;
    bus.i_mul_done  = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic wait_rsp(string tag);
    int n;
    n = 0;
    step();
    while (!bus.o_rsp_valid && n < 80) begin
      step();
      n++;
    end
    chk({tag, "_rsp_seen"}, bus.o_rsp_valid, 1);
  endtask

  task automatic wait_stage0(string tag);
    int n;
    n = 0;
    while ((m_stage != 0 || xfer_count < cfg_limit) && n < 400) begin
      step();
      n++;
    end
    chk({tag, "_drained"}, (m_stage == 0 && xfer_count >= cfg_limit), 1);
  endtask

  task automatic check_all_zero(string tag);
    chk({tag, "_req_ready"}, bus.o_req_ready, 0);
    chk({tag, "_start"}, bus.o_mul_start, 0);
    chk({tag, "_mul_m"}, bus.o_mul_m, 0);
    chk({tag, "_mul_q"}, bus.o_mul_q, 0);
    chk({tag, "_rsp_valid"}, bus.o_rsp_valid, 0);
    chk({tag, "_rsp_id"}, bus.o_rsp_id, 0);
    chk({tag, "_rsp_product"}, bus.o_rsp_product, 0);
    chk({tag, "_rsp_err"}, bus.o_rsp_err, 0);
  endtask

  initial begin
    int sp0, g0, n;
    int exp_order[5];
    exp_order = '{0, 1, 2, 3, 0};
    for (int k = 0; k < N; k++) begin
      cfg_a[k] = '0;
      cfg_b[k] = '0;
    end
    rst_n = 1'b0;
    bus.i_req_valid = '0;
    bus.i_req_a = '0;
    bus.i_req_b = '0;
    bus.i_mul_done = 1'b0;
    bus.i_mul_product = '0;
    bus.i_rsp_ready = 1'b0;
    repeat (3) step();
    rst_n = 1'b1;
    check_all_zero("reset");

    // single request from id 2: +3 * -2, done on the 9th cycle after start
    cfg_valid = 4'b0100; cfg_a[2] = 4'b0011; cfg_b[2] = 4'b1110;
    cfg_limit = xfer_count + 1; cfg_done_at = 9; cfg_rsp_mode = 0;
    sp0 = start_pulses;
    wait_rsp("t1");
    chk("t1_id", bus.o_rsp_id, 2);
    chk("t1_prod", bus.o_rsp_product, 8'hFA);
    chk("t1_err", bus.o_rsp_err, 0);
    chk("t1_m", bus.o_mul_m, 4'b0011);
    chk("t1_q", bus.o_mul_q, 4'b1110);
    chk("t1_busy_cycles", last_busy, 9);
    wait_stage0("t1");
    chk("t1_start_pulses", start_pulses - sp0, 1);

    // all four valid held after reset: fair rotation
    do_reset();
    for (int k = 0; k < N; k++) begin
      cfg_a[k] = W'($urandom);
      cfg_b[k] = W'($urandom);
    end
    cfg_valid = 4'hF; cfg_limit = xfer_count + 5; cfg_done_at = -1;
    g0 = grants.size();
    wait_stage0("t2");
    for (int i = 0; i < 5; i++) begin
      if (grants.size() > g0 + i) chk("t2_order", grants[g0 + i], exp_order[i]);
      else chk("t2_order_missing", i, 5);
    end

    // consumer stalls 5 cycles; requester 0 stays valid throughout
    cfg_valid = 4'b0011; cfg_limit = xfer_count + 2; cfg_done_at = 3;
    cfg_rsp_mode = 2; hold_cnt = 0;
    wait_rsp("t3");
    chk("t3_id", bus.o_rsp_id, 1);
    n = 0;
    while (m_stage == 3 && n < 20) begin
      step();
      n++;
    end
    chk("t3_resp_cycles", last_resp_cycles, 6);
    wait_stage0("t3");
    cfg_rsp_mode = 0;

    // multiplier never answers: timeout after 16 busy cycles, then a normal grant
    cfg_valid = 4'b0100; cfg_limit = xfer_count + 1; cfg_done_at = 0;
    wait_rsp("t4");
    chk("t4_err", bus.o_rsp_err, 1);
    chk("t4_prod", bus.o_rsp_product, 0);
    chk("t4_busy_cycles", last_busy, 16);
    wait_stage0("t4");
    cfg_valid = 4'b1000; cfg_a[3] = 4'b1000; cfg_b[3] = 4'b1000;
    cfg_limit = xfer_count + 1; cfg_done_at = 5;
    wait_rsp("t4b");
    chk("t4b_id", bus.o_rsp_id, 3);
    chk("t4b_prod", bus.o_rsp_product, 8'h40);
    chk("t4b_err", bus.o_rsp_err, 0);
    wait_stage0("t4b");

    // reset in the middle of BUSY, stale done afterwards
    cfg_valid = 4'b0010; cfg_limit = xfer_count + 1; cfg_done_at = 0;
    n = 0;
    while (!(m_stage == 2 && m_k == 4) && n < 40) begin
      step();
      n++;
    end
    chk("t5_reached_busy", (m_stage == 2), 1);
    do_reset();
    check_all_zero("t5_after_reset");
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    repeat (3) begin
      step();
      chk("t5_stale_done_ignored", bus.o_rsp_valid, 0);
    end
    cfg_valid = 4'b1010; cfg_a[1] = 4'b0101; cfg_b[1] = 4'b0011;
    cfg_limit = xfer_count + 1; cfg_done_at = 2;
    wait_rsp("t5");
    chk("t5_grant", grants[grants.size() - 1], 1);
    chk("t5_prod", bus.o_rsp_product, 8'h0F);
    wait_stage0("t5");

    // done on the last allowed busy cycle wins over expiry
    cfg_valid = 4'b0001; cfg_a[0] = 4'b0111; cfg_b[0] = 4'b1001;
    cfg_limit = xfer_count + 1; cfg_done_at = 16;
    wait_rsp("t6");
    chk("t6_id", bus.o_rsp_id, 0);
    chk("t6_err", bus.o_rsp_err, 0);
    chk("t6_prod", bus.o_rsp_product, 8'hCF);
    chk("t6_busy_cycles", last_busy, 16);
    wait_stage0("t6");

    // random traffic, random done timing and consumer back-pressure
    cfg_rand = 1'b1; cfg_rsp_mode = 1; cfg_done_at = -1;
    repeat (3000) step();
    cfg_rand = 1'b0; cfg_limit = xfer_count; cfg_rsp_mode = 0;
    wait_stage0("rand");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
